// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_arb_pkg
//  Description : Shared definitions for the divider arbiter: FSM state
//                encoding, default operand width and requester count, and
//                the default watchdog limit for the divider handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_arb_pkg;

    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_DEFAULT_NREQ  = 4;

    // Arbiter FSM encoding, 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Longest wait for the divider's ready pulse: a radix-2 divider needs
    // about two cycles per bit, plus some slack.
    function automatic int timeout_cycles(input int width);
        return 2 * width + 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Searches req starting
//                at ptr and wrapping at NREQ; reports the first set bit.
//  Ports       : req   - request vector
//                ptr   - index with highest priority this round
//                valid - at least one request is set
//                index - winning requester index
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   index
);

    // Walk the candidates from the farthest to the nearest position after
    // ptr so the last hit written is the one closest to ptr.
    always_comb begin
        int          w_pos;
        logic [IW-1:0] w_idx;
        valid = 1'b0;
        index = '0;
        w_pos = 0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            w_idx = IW'(w_pos);
            if (req[w_idx]) begin
                valid = 1'b1;
                index = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : div_arbiter
//  Description : Round-robin arbiter sharing one divider among NREQ
//                requesters. One transaction in flight, non-preemptive.
//                Zero divisors are answered locally; a watchdog bounds the
//                wait for the divider's ready pulse.
//  Ports       : clk, reset            - clock, async active-high reset
//                req/req_*             - per-requester request and operands
//                div_*  (out)          - launch and operands to the divider
//                div_*  (in)           - divider results and ready pulse
//                done                  - one-hot completion pulse
//                quotient_out,
//                remainder_out         - result, held until the next done
//                div0, timeout_err     - status of the current done pulse
//                busy, grant_id        - activity and served requester
//  Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int NREQ    = c_DEFAULT_NREQ,
    parameter int TIMEOUT = timeout_cycles(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_dividend,
    input  logic [NREQ*WIDTH-1:0]   req_divisor,
    input  logic [NREQ-1:0]         req_sign,
    output logic                    div_start,
    output logic                    div_sign,
    output logic [WIDTH-1:0]        div_dividend,
    output logic [WIDTH-1:0]        div_divisor,
    input  logic [WIDTH-1:0]        div_quotient,
    input  logic [WIDTH-1:0]        div_fractional,
    input  logic                    div_ready,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        quotient_out,
    output logic [WIDTH-1:0]        remainder_out,
    output logic                    div0,
    output logic                    timeout_err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_CW = $clog2(TIMEOUT + 1);

    arb_state_t         r_state;
    logic [c_IW-1:0]    r_ptr;
    logic [c_IW-1:0]    r_grant;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_sign;
    logic               r_div_start;
    logic [NREQ-1:0]    r_done;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_div0;
    logic               r_tout;
    logic [c_CW-1:0]    r_wdog;

    logic               w_pick_valid;
    logic [c_IW-1:0]    w_pick_idx;
    logic [WIDTH-1:0]   w_pick_dividend;
    logic [WIDTH-1:0]   w_pick_divisor;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (c_IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .index (w_pick_idx)
    );

    assign w_pick_dividend = req_dividend[int'(w_pick_idx) * WIDTH +: WIDTH];
    assign w_pick_divisor  = req_divisor[int'(w_pick_idx) * WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_sign      <= 1'b0;
            r_div_start <= 1'b0;
            r_done      <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_div0      <= 1'b0;
            r_tout      <= 1'b0;
            r_wdog      <= '0;
        end else begin
            // Pulsed outputs default low; the branches below raise them
            // for exactly one cycle.
            r_div_start <= 1'b0;
            r_done      <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant     <= w_pick_idx;
                        r_dividend  <= w_pick_dividend;
                        r_divisor   <= w_pick_divisor;
                        r_sign      <= req_sign[w_pick_idx];
                        // div_start is registered, so it is decided here
                        // to be high during the LAUNCH cycle itself.
                        r_div_start <= (w_pick_divisor != '0);
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (r_divisor == '0) begin
                        r_quot  <= '1;
                        r_rem   <= r_dividend;
                        r_div0  <= 1'b1;
                        r_done  <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
                        r_state <= ST_DONE;
                    end else begin
                        r_wdog  <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A ready on the final watchdog cycle still wins.
                    if (div_ready) begin
                        r_quot  <= div_quotient;
                        r_rem   <= div_fractional;
                        r_done  <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
                        r_state <= ST_DONE;
                    end else if (r_wdog == c_CW'(TIMEOUT - 1)) begin
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_tout  <= 1'b1;
                        r_done  <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
                        r_state <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + c_CW'(1);
                    end
                end
                ST_DONE: begin
                    // Status flags describe only the pulse just delivered.
                    r_div0 <= 1'b0;
                    r_tout <= 1'b0;
                    if (r_grant == c_IW'(NREQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_grant + c_IW'(1);
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_start     = r_div_start;
    assign div_sign      = r_sign;
    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign done          = r_done;
    assign quotient_out  = r_quot;
    assign remainder_out = r_rem;
    assign div0          = r_div0;
    assign timeout_err   = r_tout;
    assign busy          = (r_state != ST_IDLE);
    assign grant_id      = r_grant;

endmodule
`default_nettype wire
